// File: rtl/duty_btn_pkg.sv
// Shared types and defaults for the duty-cycle button conditioner.
// Holds the repeat-FSM state encoding and the default timing constants.
package duty_btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_DELAY    = 64;
  localparam int unsigned DEF_REPEAT_PERIOD   = 32;
  localparam bit          DEF_REPEAT_EN       = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/duty_button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level
// and the press/auto-repeat FSM producing an unmasked step pulse.
module button_channel
  import duty_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_button,
  output logic o_pulse,
  output logic o_level
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       r_sync;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_level;
  rpt_state_e       r_state;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_pulse;

  logic w_differs;
  logic w_toggle;
  logic w_rise;
  logic w_fall;

  // The synchronizer keeps sampling while disabled so a held button is
  // already resolved when the channel is re-enabled.
  // NOTE: every clocked block uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_button};
  end

  assign w_differs = (r_sync[1] != r_level);
  assign w_toggle  = w_differs && (r_db_cnt == DB_LAST);
  assign w_rise    = w_toggle && !r_level;
  assign w_fall    = w_toggle &&  r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (!i_enable) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (!w_differs) begin
      r_db_cnt <= '0;
    end else if (w_toggle) begin
      r_db_cnt <= '0;
      r_level  <= ~r_level;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // The FSM acts on the debounce toggle itself, so the first pulse lands on
  // the same edge the stable level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rpt_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      // NOTE: defaulting the pulse low here makes every pulse exactly one cycle.
      r_pulse <= 1'b0;
      if (!i_enable || w_fall) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_pulse   <= 1'b1;
              r_rpt_cnt <= '0;
              r_state   <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (r_rpt_cnt == DELAY_LAST) begin
              if (REPEAT_EN) begin
                r_pulse   <= 1'b1;
                r_rpt_cnt <= '0;
                r_state   <= ST_REPEAT;
              end
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_rpt_cnt == PERIOD_LAST) begin
              r_pulse   <= 1'b1;
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/duty_button_conditioner.sv
// Conditions the increase/decrease duty buttons into clean step pulses,
// with mutual exclusion between channels and a registered block enable.
module duty_button_conditioner
  import duty_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic ui_increase_duty,
  input  logic ui_decrease_duty,
  output logic uo_increase_pulse,
  output logic uo_decrease_pulse,
  output logic uo_increase_level,
  output logic uo_decrease_level
);

  logic r_ena;
  logic w_inc_pulse;
  logic w_dec_pulse;
  logic w_inc_level;
  logic w_dec_level;

  // Registered enable: outputs drop one edge after ena falls, and the
  // channels are cleared from that point until ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ena <= 1'b0;
    else        r_ena <= ena;
  end

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (REPEAT_EN)
  ) u_inc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (r_ena),
    .i_button (ui_increase_duty),
    .o_pulse  (w_inc_pulse),
    .o_level  (w_inc_level)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (REPEAT_EN)
  ) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (r_ena),
    .i_button (ui_decrease_duty),
    .o_pulse  (w_dec_pulse),
    .o_level  (w_dec_level)
  );

  // Outputs are ANDs of flops only; a pulse is suppressed whenever the other
  // button is held, while its repeat schedule keeps running underneath.
  assign uo_increase_level = w_inc_level & r_ena;
  assign uo_decrease_level = w_dec_level & r_ena;
  assign uo_increase_pulse = w_inc_pulse & r_ena & ~w_dec_level;
  assign uo_decrease_pulse = w_dec_pulse & r_ena & ~w_inc_level;

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed bench for duty_button_conditioner: pulse timing, debounce,
// auto-repeat, channel conflict, enable drop and asynchronous reset.
module tb_duty_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic ui_increase_duty;
  logic ui_decrease_duty;
  logic uo_increase_pulse, uo_decrease_pulse, uo_increase_level, uo_decrease_level;
  logic nr_inc_pulse, nr_dec_pulse, nr_inc_level, nr_dec_level;

  always #5 clk = ~clk;

  duty_button_conditioner dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ena               (ena),
    .ui_increase_duty  (ui_increase_duty),
    .ui_decrease_duty  (ui_decrease_duty),
    .uo_increase_pulse (uo_increase_pulse),
    .uo_decrease_pulse (uo_decrease_pulse),
    .uo_increase_level (uo_increase_level),
    .uo_decrease_level (uo_decrease_level)
  );

  duty_button_conditioner #(.REPEAT_EN(1'b0)) dut_norep (
    .clk               (clk),
    .rst_n             (rst_n),
    .ena               (ena),
    .ui_increase_duty  (ui_increase_duty),
    .ui_decrease_duty  (ui_decrease_duty),
    .uo_increase_pulse (nr_inc_pulse),
    .uo_decrease_pulse (nr_dec_pulse),
    .uo_increase_level (nr_inc_level),
    .uo_decrease_level (nr_dec_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Edge counter: after rising edge N, cyc reads N at the following negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int inc_q[$];
  int dec_q[$];
  int nr_inc_q[$];
  int nr_dec_q[$];
  int inc_lvl_cnt = 0;
  int dec_lvl_cnt = 0;
  int viol = 0;
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  always @(negedge clk) begin
    if (uo_increase_pulse) inc_q.push_back(cyc);
    if (uo_decrease_pulse) dec_q.push_back(cyc);
    if (nr_inc_pulse)      nr_inc_q.push_back(cyc);
    if (nr_dec_pulse)      nr_dec_q.push_back(cyc);
    if (uo_increase_level) inc_lvl_cnt++;
    if (uo_decrease_level) dec_lvl_cnt++;
    if (uo_increase_pulse && uo_decrease_pulse) viol++;
    if ((uo_increase_pulse && prev_inc) || (uo_decrease_pulse && prev_dec)) viol++;
    prev_inc = uo_increase_pulse;
    prev_dec = uo_decrease_pulse;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_train(input string tag, input int q[$], input int base, input int exp[$]);
    check({tag, "_count"}, q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < q.size()) check({tag, "_cycle"}, q[base + i], exp[i]);
      else                     check({tag, "_cycle"}, -1, exp[i]);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k, e0, ib, db, nib, ndb, il, dl;
  int exp_q[$];

  task automatic snap();
    ib  = inc_q.size();
    db  = dec_q.size();
    nib = nr_inc_q.size();
    ndb = nr_dec_q.size();
    il  = inc_lvl_cnt;
    dl  = dec_lvl_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    ui_increase_duty = 1'b0;
    ui_decrease_duty = 1'b0;

    // Reset held with buttons toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ui_increase_duty = i[0];
      ui_decrease_duty = ~i[0];
      if (i == 4 || i == 9) begin
        check("rst_outputs", {uo_increase_pulse, uo_decrease_pulse,
                              uo_increase_level, uo_decrease_level}, 0);
        check("rst_outputs_norep", {nr_inc_pulse, nr_dec_pulse, nr_inc_level, nr_dec_level}, 0);
      end
    end
    ui_increase_duty = 1'b0;
    ui_decrease_duty = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    wait_cycles(200);
    check("idle_inc_pulses", inc_q.size() - ib, 0);
    check("idle_dec_pulses", dec_q.size() - db, 0);

    // Clean 10-cycle press on increase
    snap();
    ui_increase_duty = 1'b1;
    k = cyc + 1;
    wait_cycles(10);
    ui_increase_duty = 1'b0;
    wait_cycles(30);
    exp_q = {k + 5};
    check_train("press_inc", inc_q, ib, exp_q);
    check_train("press_inc_norep", nr_inc_q, nib, exp_q);
    check("press_inc_level_cycles", inc_lvl_cnt - il, 10);
    check("press_dec_pulses", dec_q.size() - db, 0);

    // Bouncing decrease: 2-cycle runs never satisfy the debounce
    snap();
    for (int i = 0; i < 10; i++) begin
      ui_decrease_duty = ~i[0];
      wait_cycles(2);
    end
    ui_decrease_duty = 1'b0;
    wait_cycles(40);
    check("bounce_dec_pulses", dec_q.size() - db, 0);
    check("bounce_dec_level_cycles", dec_lvl_cnt - dl, 0);

    // Auto-repeat: hold decrease 200 cycles
    snap();
    ui_decrease_duty = 1'b1;
    k = cyc + 1;
    wait_cycles(200);
    ui_decrease_duty = 1'b0;
    wait_cycles(40);
    exp_q = {k + 5, k + 69, k + 101, k + 133, k + 165, k + 197};
    check_train("repeat_dec", dec_q, db, exp_q);
    exp_q = {k + 5};
    check_train("repeat_dec_norep", nr_dec_q, ndb, exp_q);
    check("repeat_dec_level_cycles", dec_lvl_cnt - dl, 200);

    // Conflict: decrease held inside an increase hold
    snap();
    ui_increase_duty = 1'b1;
    k = cyc + 1;
    wait_cycles(20);
    ui_decrease_duty = 1'b1;
    wait_cycles(100);
    ui_decrease_duty = 1'b0;
    wait_cycles(50);
    ui_increase_duty = 1'b0;
    wait_cycles(30);
    exp_q = {k + 5, k + 133, k + 165};
    check_train("conflict_inc", inc_q, ib, exp_q);
    check("conflict_dec_pulses", dec_q.size() - db, 0);
    check("conflict_dec_level_cycles", dec_lvl_cnt - dl, 100);

    // Enable dropped mid-repeat, then restored with the button still held
    snap();
    ui_increase_duty = 1'b1;
    k = cyc + 1;
    wait_cycles(80);
    check("ena_pre_level", uo_increase_level, 1);
    ena = 1'b0;
    wait_cycles(1);
    check("ena_off_level", uo_increase_level, 0);
    wait_cycles(9);
    check("ena_off_level_late", uo_increase_level, 0);
    ena = 1'b1;
    e0 = cyc;
    wait_cycles(75);
    ui_increase_duty = 1'b0;
    wait_cycles(20);
    exp_q = {k + 5, k + 69, e0 + 5, e0 + 69};
    check_train("ena_inc", inc_q, ib, exp_q);

    // Asynchronous reset mid-repeat
    snap();
    ui_increase_duty = 1'b1;
    k = cyc + 1;
    wait_cycles(80);
    check("rst_pre_level", uo_increase_level, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {uo_increase_pulse, uo_decrease_pulse,
                                   uo_increase_level, uo_decrease_level}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(90);
    ui_increase_duty = 1'b0;
    wait_cycles(20);
    exp_q = {k + 5, k + 69, k + 86, k + 150};
    check_train("rst_inc", inc_q, ib, exp_q);

    check("pulse_rule_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
